// File: rtl/dmem_sram_bridge_if.sv
// dmem_sram_bridge_if: M-stage request/response and SRAM-like data bus signals for the bridge
interface dmem_sram_bridge_if;
  logic        mem_en;
  logic        mem_wr;
  logic [3:0]  mem_wea;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        pipe_adv;
  logic        flush;
  logic [31:0] mem_rdata;
  logic        stall;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  modport master (
    output mem_en, mem_wr, mem_wea, mem_addr, mem_wdata, pipe_adv, flush,
           data_addr_ok, data_data_ok, data_rdata,
    input  mem_rdata, stall, data_req, data_wr, data_size, data_addr, data_wdata
  );
  modport slave (
    input  mem_en, mem_wr, mem_wea, mem_addr, mem_wdata, pipe_adv, flush,
           data_addr_ok, data_data_ok, data_rdata,
    output mem_rdata, stall, data_req, data_wr, data_size, data_addr, data_wdata
  );
endinterface

// File: rtl/dmem_sram_bridge.sv
// dmem_sram_bridge: turns one M-stage memory request into a req/addr_ok/data_ok bus transaction, stalling until done
module dmem_sram_bridge #(
  parameter bit KSEG_TRANSLATE = 1'b1,
  parameter int ADDR_W         = 32
) (
  input logic               clk,
  input logic               rst,
  dmem_sram_bridge_if.slave bus
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  state_t            r_state, w_next;
  logic              r_cancel, r_wr;
  logic [1:0]        r_size, w_size;
  logic [ADDR_W-1:0] r_addr, w_addr;
  logic [31:0]       r_wdata, r_rdata;
  logic              w_cancel, w_latch, w_resp, w_cap;
  assign w_cancel = r_cancel || bus.flush;
  assign w_latch  = r_state == IDLE && bus.mem_en && !bus.flush;
  assign w_resp   = bus.data_data_ok && (r_state == WAIT || (r_state == REQ && bus.data_addr_ok));
  assign w_cap    = w_resp && !r_wr && !w_cancel;
  assign w_addr   = (KSEG_TRANSLATE && bus.mem_addr[31:30] == 2'b10) ? {3'b000, bus.mem_addr[28:0]} : bus.mem_addr;
  assign w_size   = !bus.mem_wr ? 2'd2 :
                    $onehot(bus.mem_wea) ? 2'd0 :
                    (bus.mem_wea == 4'b0011 || bus.mem_wea == 4'b1100) ? 2'd1 : 2'd2;
  // State register
  always_ff @(posedge clk)
    r_state <= rst ? IDLE : w_next;
  // Next state: a cancelled transaction still runs to its response, then returns to IDLE instead of DONE
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: w_next = w_latch ? REQ : IDLE;
      REQ:  w_next = !bus.data_addr_ok ? REQ : !bus.data_data_ok ? WAIT : w_cancel ? IDLE : DONE;
      WAIT: w_next = !bus.data_data_ok ? WAIT : w_cancel ? IDLE : DONE;
      DONE: w_next = (bus.pipe_adv || bus.flush) ? IDLE : DONE;
    endcase
  end
  // Cancel flag: set by a flush while the bus is busy, cleared on return to IDLE
  always_ff @(posedge clk)
    r_cancel <= (rst || w_next == IDLE) ? 1'b0 : r_cancel || (bus.flush && (r_state == REQ || r_state == WAIT));
  // Request fields latched in IDLE and held for the whole transaction; load data captured on response
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr    <= 1'b0;
      r_size  <= 2'd0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      if (w_latch) begin
        r_wr    <= bus.mem_wr;
        r_size  <= w_size;
        r_addr  <= bus.mem_wr ? w_addr : {w_addr[ADDR_W-1:2], 2'b00};
        r_wdata <= bus.mem_wdata;
      end
      if (w_cap) r_rdata <= bus.data_rdata;
    end
  end
  assign bus.stall      = bus.mem_en && r_state != DONE && !bus.flush;
  assign bus.data_req   = r_state == REQ;
  assign bus.data_wr    = r_wr;
  assign bus.data_size  = r_size;
  assign bus.data_addr  = r_addr;
  assign bus.data_wdata = r_wdata;
  assign bus.mem_rdata  = r_rdata;
endmodule

// File: doc/dmem_sram_bridge.md
Name: dmem_sram_bridge

Overview:
Sits directly downstream of the M-stage memory byte-select logic. It turns that logic's per-instruction request (byte enables, address, lane-aligned write data, read/write flag) into a multi-cycle SRAM-like data bus transaction (req/addr_ok/data_ok). It stalls the pipeline until the transaction completes. It returns the raw 32-bit read word back to the byte-select logic and holds it until the M stage advances.

Parameters:
KSEG_TRANSLATE, 1, when 1 map kseg0/kseg1 virtual addresses (addr[31:29] = 3'b100 or 3'b101) to physical by forcing addr[31:29] = 3'b000; other addresses pass through unchanged
ADDR_W, 32, address width (only 32 supported)

Ports:
clk  in  1  clock, rising-edge
rst  in  1  synchronous, active-high reset
mem_en  in  1  M stage holds a load/store with no address exception (already gated upstream)
mem_wr  in  1  1 = store, 0 = load
mem_wea  in  4  byte enables from byte-select logic (loads always present 4'b1111)
mem_addr  in  32  byte address (aluoutM)
mem_wdata  in  32  lane-aligned store data
pipe_adv  in  1  M stage advances this cycle (no other stall source)
flush  in  1  pipeline flush (exception/eret)
mem_rdata  out  32  raw read word to the byte-select logic
stall  out  1  stall request to the hazard unit
data_req  out  1  bus request
data_wr  out  1  bus write flag
data_size  out  2  0 = byte, 1 = half, 2 = word
data_addr  out  32  bus byte address
data_wdata  out  32  bus write data
data_addr_ok  in  1  request accepted
data_data_ok  in  1  read data valid / write done
data_rdata  in  32  bus read data

Behaviour:
- FSM states: IDLE, REQ, WAIT, DONE, plus a registered cancel flag.
- Reset: state IDLE, cancel 0. data_req, data_wr, data_size, data_addr, data_wdata, mem_rdata all 0.
- stall is combinational: stall = mem_en & (state != DONE) & ~flush. It is therefore 0 after reset while mem_en = 0.
- IDLE:
  - If mem_en & ~flush, latch all request fields and go to REQ.
  - Latched fields: data_wr = mem_wr; data_wdata = mem_wdata; data_addr = translated mem_addr.
  - Loads: data_size = 2 and data_addr[1:0] forced to 00.
  - Stores: size from wea: one-hot -> 0; 4'b0011 or 4'b1100 -> 1; 4'b1111 -> 2. Any other wea on a store is treated as size 2.
  - Stores keep the full byte address.
- REQ:
  - data_req = 1; all bus fields held stable until data_addr_ok.
  - On addr_ok go to WAIT, or straight to DONE if data_ok is also high the same cycle.
  - data_req drops the cycle after acceptance.
- WAIT:
  - On data_ok, a load captures data_rdata into mem_rdata (a store leaves mem_rdata unchanged), then go to DONE.
  - If cancel is set, mem_rdata is not updated and the next state is IDLE.
  - data_ok outside REQ/WAIT is ignored.
- DONE:
  - stall = 0 and mem_rdata is held.
  - On pipe_adv or flush go to IDLE.
  - Otherwise stay in DONE with no new request, even though mem_en is still high (same instruction).
- Flush:
  - In IDLE: no request is issued.
  - In REQ: req cannot be withdrawn. Set cancel; the transaction runs to completion and its result is discarded.
  - In WAIT: set cancel.
  - cancel clears on entry to IDLE.
  - A new mem_en arriving while cancelling sees stall = 1 until the FSM returns to IDLE.
- Latency, best case: IDLE (latch) -> REQ (addr_ok) -> WAIT (data_ok) -> DONE. stall is high for 3 cycles and mem_rdata is valid in the 4th.
- Reset mid-transaction: the FSM returns to IDLE immediately and outstanding bus responses are ignored. The bus agent shares rst.

Test Plan:
1. lw at mem_addr 0x8000_0104; addr_ok on first REQ cycle; data_ok next cycle with 0xDEADBEEF -> data_addr = 0x0000_0104, size 2, wr 0, stall high exactly 3 cycles, mem_rdata = 0xDEADBEEF in DONE.
2. lb at 0x8000_0107 (wea 4'b1111, mem_wr 0) -> data_addr = 0x0000_0104, data_size 2.
3. sb at 0xA000_0013, wea 4'b1000, wdata 0x5A00_0000 -> data_addr = 0x0000_0013, size 0, wr 1, data_wdata = 0x5A00_0000. sh with wea 4'b1100 -> size 1.
4. addr_ok delayed 4 cycles -> data_req and all bus fields constant for all 5 REQ cycles; req low on the following cycle.
5. pipe_adv low for 2 cycles in DONE with mem_en high -> stall 0, mem_rdata stable, no second data_req. pipe_adv high -> IDLE.
6. flush during WAIT, then data_ok with 0x1234_5678 -> FSM goes to IDLE (never DONE) and mem_rdata keeps its previous value. rst asserted in WAIT -> all outputs 0 next cycle and a later data_ok causes no change.
